// File: rtl/mem_req_arbiter_2x1_pkg.sv
// Shared constants for the two-client memory request arbiter: client IDs and
// the default flat widths of the MemMsg request/response messages.
package mem_req_arbiter_2x1_pkg;

    localparam logic MEM_ARB_CLIENT0 = 1'b0;
    localparam logic MEM_ARB_CLIENT1 = 1'b1;

    // MEM_REQ(32,32,8): type(4) opaque(8) addr(32) len(2) data(32)
    localparam int MEM_REQ_W  = 78;
    // MEM_RESP(32,32,8): type(4) opaque(8) test(2) len(2) data(32)
    localparam int MEM_RESP_W = 48;

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order ID FIFO recording which client owns each outstanding request.
// Power-of-two depth so the pointers wrap naturally.
module mem_arb_id_fifo #(
    parameter int p_depth = 4,
    parameter int p_width = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [p_width-1:0] din,
    output logic               full,
    output logic               empty,
    output logic [p_width-1:0] head
);

    localparam int AW = $clog2(p_depth);
    localparam int CW = AW + 1;

    logic [p_width-1:0] mem [p_depth];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;

    assign full  = (count == CW'(p_depth));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/mem_req_arbiter_2x1.sv
// Round-robin 2:1 memory request arbiter with in-order response steering.
// Define MEM_REQ_ARBITER_STATS_EN to add grant and full-stall counter outputs.
module mem_req_arbiter_2x1
    import mem_req_arbiter_2x1_pkg::*;
#(
    parameter type t_req_msg      = logic [MEM_REQ_W-1:0],
    parameter type t_resp_msg     = logic [MEM_RESP_W-1:0],
    parameter int  p_max_inflight = 4
) (
    input  logic      clk,
    input  logic      rst,

    input  logic      c0_req_val,
    output logic      c0_req_rdy,
    input  t_req_msg  c0_req_msg,
    output logic      c0_resp_val,
    input  logic      c0_resp_rdy,
    output t_resp_msg c0_resp_msg,

    input  logic      c1_req_val,
    output logic      c1_req_rdy,
    input  t_req_msg  c1_req_msg,
    output logic      c1_resp_val,
    input  logic      c1_resp_rdy,
    output t_resp_msg c1_resp_msg,

    output logic      mem_req_val,
    input  logic      mem_req_rdy,
    output t_req_msg  mem_req_msg,
    input  logic      mem_resp_val,
    output logic      mem_resp_rdy,
    input  t_resp_msg mem_resp_msg
`ifdef MEM_REQ_ARBITER_STATS_EN
    ,
    output logic [31:0] grant_cnt0,
    output logic [31:0] grant_cnt1,
    output logic [31:0] full_stall_cnt
`endif
);

    // Handshake: a transfer happens on a cycle where val & rdy are both high;
    // val never depends on rdy of the same interface.

    logic prio;
    logic sel;
    logic any_req;
    logic full;
    logic empty;
    logic head;
    logic req_fire;
    logic resp_fire;

    assign any_req = c0_req_val | c1_req_val;

    always_comb begin
        sel = MEM_ARB_CLIENT0;
        if (c0_req_val && c1_req_val) begin
            sel = prio;
        end else if (c1_req_val) begin
            sel = MEM_ARB_CLIENT1;
        end
    end

    // Grants depend only on the FIFO count, never on a same-cycle pop.
    assign mem_req_val = any_req & ~full;
    assign mem_req_msg = (sel == MEM_ARB_CLIENT1) ? c1_req_msg : c0_req_msg;
    assign c0_req_rdy  = c0_req_val & (sel == MEM_ARB_CLIENT0) & mem_req_rdy & ~full;
    assign c1_req_rdy  = c1_req_val & (sel == MEM_ARB_CLIENT1) & mem_req_rdy & ~full;
    assign req_fire    = mem_req_val & mem_req_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= MEM_ARB_CLIENT0;
        end else if (req_fire) begin
            prio <= ~sel;
        end
    end

    assign c0_resp_msg  = mem_resp_msg;
    assign c1_resp_msg  = mem_resp_msg;
    assign c0_resp_val  = mem_resp_val & ~empty & (head == MEM_ARB_CLIENT0);
    assign c1_resp_val  = mem_resp_val & ~empty & (head == MEM_ARB_CLIENT1);
    assign mem_resp_rdy = ~empty & ((head == MEM_ARB_CLIENT1) ? c1_resp_rdy : c0_resp_rdy);
    assign resp_fire    = mem_resp_val & mem_resp_rdy;

    mem_arb_id_fifo #(
        .p_depth (p_max_inflight),
        .p_width (1)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .pop   (resp_fire),
        .din   (sel),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

`ifdef MEM_REQ_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0     <= '0;
            grant_cnt1     <= '0;
            full_stall_cnt <= '0;
        end else begin
            if (req_fire && sel == MEM_ARB_CLIENT0) begin
                grant_cnt0 <= grant_cnt0 + 32'd1;
            end
            if (req_fire && sel == MEM_ARB_CLIENT1) begin
                grant_cnt1 <= grant_cnt1 + 32'd1;
            end
            if (any_req && full) begin
                full_stall_cnt <= full_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/mem_req_arbiter_2x1.md
Name: mem_req_arbiter_2x1

Overview:
- Shares one memory server port between two requesters, client 0 and client 1.
- Arbitrates between the two clients' requests using round-robin.
- Records the client ID of each granted request in an in-order ID FIFO, and uses it to steer each returning response to its client.
- Sits between the processor-side units (fetch, load/store) and a single memory or cache server.
- Fully synthesizable; adds zero cycles of latency on both the request and response paths.

Parameters:
- t_req_msg, `MEM_REQ(32,32,8)`, request message struct type.
- t_resp_msg, `MEM_RESP(32,32,8)`, response message struct type.
- p_max_inflight, 4, maximum number of outstanding requests (ID FIFO depth); must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- c0_req_val  in  1  client 0 request valid
- c0_req_rdy  out  1  client 0 request ready
- c0_req_msg  in  t_req_msg  client 0 request message
- c0_resp_val  out  1  client 0 response valid
- c0_resp_rdy  in  1  client 0 response ready
- c0_resp_msg  out  t_resp_msg  client 0 response message
- c1_req_val, c1_req_rdy, c1_req_msg, c1_resp_val, c1_resp_rdy, c1_resp_msg: identical to the client 0 ports, for client 1
- mem_req_val  out  1  server request valid
- mem_req_rdy  in  1  server request ready
- mem_req_msg  out  t_req_msg  server request message
- mem_resp_val  in  1  server response valid
- mem_resp_rdy  out  1  server response ready
- mem_resp_msg  in  t_resp_msg  server response message

Behaviour:
- State: a 1-bit priority pointer `prio` (the client that wins a tie) and the ID FIFO (1-bit entries, depth p_max_inflight).
- Reset: `prio`=0, FIFO empty. With the FIFO empty, all rdy/val outputs driven by the block are 0 unless a client request is pending.
- Request grant is combinational:
  - `sel` = `prio` if both clients are valid; otherwise the one valid client.
  - mem_req_val = (c0_req_val | c1_req_val) & !full.
  - mem_req_msg = request of client `sel`, passed through unmodified (opaque untouched).
  - cN_req_rdy = (sel==N) & mem_req_rdy & !full.
- Request fire (mem_req_val & mem_req_rdy):
  - push `sel` into the FIFO;
  - `prio` <= ~sel, so the loser of this cycle has priority next cycle.
  - When only one client is active it may fire every cycle.
- Response routing is combinational, using the FIFO head `h`:
  - ch_resp_val = mem_resp_val & !empty;
  - ch_resp_msg = mem_resp_msg, broadcast to both clients; only client `h` sees val;
  - mem_resp_rdy = !empty & ch_resp_rdy.
  - Response fire pops the FIFO.
- Boundary cases:
  - FIFO full: no grants; a pop in the same cycle does NOT enable a push. This keeps req_rdy independent of the response path.
  - FIFO empty: mem_resp_rdy=0; a server response with nothing outstanding is held off, never dropped.
  - Same-cycle push and pop: both occur; count unchanged.
  - The server must return responses in order; this is a documented precondition, not checked.
  - rst mid-operation: FIFO cleared and outstanding IDs lost; the server must also be reset in the same cycle.
- Pointers wrap modulo p_max_inflight. Count is $clog2(p_max_inflight)+1 bits wide.

Optional Feature:
- MEM_REQ_ARBITER_STATS_EN: adds output ports `grant_cnt0` and `grant_cnt1` (32 bits each, wrapping) and `full_stall_cnt` (32 bits).
  - grant_cntN increments on each request fire from client N.
  - full_stall_cnt increments each cycle in which any client request is valid but `full` blocks the grant.
  - All three counters reset to 0.
- Without the macro: these ports and registers do not exist; functional behaviour is identical.

Decomposition:
- Shared package: no new typedefs; message types come from the existing MemMsg types.
- Package constants: MEM_ARB_CLIENT0=1'b0, MEM_ARB_CLIENT1=1'b1.
- Sub-module: `mem_arb_id_fifo` (parameters p_depth and p_width=1; ports push/pop/full/empty/head). It is reusable for a future N-way version.

Test Plan:
- Only c0 issues 3 reads (addrs 0x100, 0x104, 0x108), memory returns data 0xA, 0xB, 0xC -> the 3 responses arrive at c0 in order; c1_resp_val is never asserted.
- c0 and c1 both continuously valid after reset -> grant order c0, c1, c0, c1; each client receives its own addr in the response (c0 0x200, c1 0x300).
- p_max_inflight=4, server never responds -> 4 grants, then both req_rdy=0; with stats enabled, full_stall_cnt increments once per subsequent cycle.
- FIFO full, then 1 response fires -> next cycle exactly one new grant; no grant in the pop cycle itself.
- Head is c1 and c1_resp_rdy=0 for 5 cycles -> mem_resp_rdy=0 for those 5 cycles; c0 gets nothing until c1 accepts.
- Reset asserted with 2 requests in flight -> FIFO empty, `prio`=0, mem_resp_rdy=0 the cycle after reset deasserts.
